// File: rtl/proc_scycle.sv
// rtl/proc_scycle.sv - single-cycle TinyRV1 processor core
//
// Purpose: fetches, executes and commits one TinyRV1 instruction per clock
// (add, addi, mul, lw, sw, jal, jr, bne). Instruction and data memories answer
// combinationally in the same cycle. Three word addresses are mapped to the
// in0..in2 input ports (loads) and the out0..out2 output registers (stores).
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   imemreq_val/addr         fetch request (addr is the current PC)
//   imemresp_data            fetched instruction word
//   dmemreq_val/type         data request valid; type 0 = read, 1 = write
//   dmemreq_addr/wdata       data address (rs1 + imm) and store data (rs2)
//   dmemresp_rdata           load data
//   in0..in2 / out0..out2    memory-mapped input ports / registered outputs
//   trace_val/addr/data      commit trace: PC and value written to rd

module proc_scycle (
  input  logic        clk,
  input  logic        rst,
  output logic        imemreq_val,
  output logic [31:0] imemreq_addr,
  input  logic [31:0] imemresp_data,
  output logic        dmemreq_val,
  output logic        dmemreq_type,
  output logic [31:0] dmemreq_addr,
  output logic [31:0] dmemreq_wdata,
  input  logic [31:0] dmemresp_rdata,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] out0,
  output logic [31:0] out1,
  output logic [31:0] out2,
  output logic        trace_val,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] IO_ADDR0 = 32'h0000_2000;
  localparam logic [31:0] IO_ADDR1 = 32'h0000_2004;
  localparam logic [31:0] IO_ADDR2 = 32'h0000_2008;

  // Architectural state
  logic [31:0] pc_q, pc_d;
  logic [31:0] out0_q, out0_d;
  logic [31:0] out1_q, out1_d;
  logic [31:0] out2_q, out2_d;
  logic [31:0] rf_q [0:31];

  // Instruction fields
  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign inst   = imemresp_data;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  // Immediates, all sign-extended from bit 31
  logic [31:0] imm_i, imm_s, imm_b, imm_j;

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Decode; anything not matched falls through as a no-op
  logic is_add, is_mul, is_addi, is_lw, is_sw, is_jal, is_jr, is_bne;

  assign is_add  = (opcode == OP_REG)    && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_mul  = (opcode == OP_REG)    && (funct3 == 3'b000) && (funct7 == 7'b0000001);
  assign is_addi = (opcode == OP_IMM)    && (funct3 == 3'b000);
  assign is_lw   = (opcode == OP_LOAD)   && (funct3 == 3'b010);
  assign is_sw   = (opcode == OP_STORE)  && (funct3 == 3'b010);
  assign is_jal  = (opcode == OP_JAL);
  // jr is only the jalr form with rd = x0 and a zero offset
  assign is_jr   = (opcode == OP_JALR)   && (funct3 == 3'b000) && (rd == 5'd0)
                   && (inst[31:20] == 12'd0);
  assign is_bne  = (opcode == OP_BRANCH) && (funct3 == 3'b001);

  // Register file reads; x0 is hard-wired to zero
  logic [31:0] rs1_val, rs2_val;

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  // Datapath
  logic [31:0] pc_plus4;
  logic [31:0] mem_addr;
  logic [31:0] mul_res;
  logic        is_io0, is_io1, is_io2, is_io;

  assign pc_plus4 = pc_q + 32'd4;
  assign mem_addr = rs1_val + (is_sw ? imm_s : imm_i);
  // Low word of the product is identical for signed and unsigned operands
  assign mul_res  = rs1_val * rs2_val;
  assign is_io0   = (mem_addr == IO_ADDR0);
  assign is_io1   = (mem_addr == IO_ADDR1);
  assign is_io2   = (mem_addr == IO_ADDR2);
  assign is_io    = is_io0 || is_io1 || is_io2;

  logic        rf_wen;
  logic [31:0] rf_wdata;
  logic        rf_we;
  logic        dmem_req;

  always_comb begin
    pc_d     = pc_plus4;
    out0_d   = out0_q;
    out1_d   = out1_q;
    out2_d   = out2_q;
    rf_wen   = 1'b0;
    rf_wdata = 32'd0;
    dmem_req = 1'b0;

    if (is_add) begin
      rf_wen   = 1'b1;
      rf_wdata = rs1_val + rs2_val;
    end else if (is_addi) begin
      rf_wen   = 1'b1;
      rf_wdata = rs1_val + imm_i;
    end else if (is_mul) begin
      rf_wen   = 1'b1;
      rf_wdata = mul_res;
    end else if (is_lw) begin
      rf_wen = 1'b1;
      if (is_io0) begin
        rf_wdata = in0;
      end else if (is_io1) begin
        rf_wdata = in1;
      end else if (is_io2) begin
        rf_wdata = in2;
      end else begin
        rf_wdata = dmemresp_rdata;
        dmem_req = 1'b1;
      end
    end else if (is_sw) begin
      if (is_io0) begin
        out0_d = rs2_val;
      end else if (is_io1) begin
        out1_d = rs2_val;
      end else if (is_io2) begin
        out2_d = rs2_val;
      end else begin
        dmem_req = 1'b1;
      end
    end else if (is_jal) begin
      rf_wen   = 1'b1;
      rf_wdata = pc_plus4;
      pc_d     = pc_q + imm_j;
    end else if (is_jr) begin
      pc_d = rs1_val & ~32'd1;
    end else if (is_bne) begin
      if (rs1_val != rs2_val) begin
        pc_d = pc_q + imm_b;
      end
    end
  end

  // Nothing commits while reset is held, so an instruction in flight when
  // reset arrives leaves no trace in the register file.
  assign rf_we = rst && rf_wen && (rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rf_we) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= 32'd0;
      out0_q <= 32'd0;
      out1_q <= 32'd0;
      out2_q <= 32'd0;
    end else begin
      pc_q   <= pc_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end

  // Outputs
  assign imemreq_val   = rst;
  assign imemreq_addr  = pc_q;
  assign dmemreq_val   = rst && dmem_req && !is_io;
  assign dmemreq_type  = is_sw;
  assign dmemreq_addr  = mem_addr;
  assign dmemreq_wdata = rs2_val;
  assign out0          = out0_q;
  assign out1          = out1_q;
  assign out2          = out2_q;
  assign trace_val     = rst;
  assign trace_addr    = pc_q;
  assign trace_data    = rf_we ? rf_wdata : 32'd0;

endmodule

// File: tb/tb_proc_scycle.sv
// tb/tb_proc_scycle.sv - self-checking bench for proc_scycle
module tb_proc_scycle;

  logic        clk;
  logic        rst;
  logic        imemreq_val;
  logic [31:0] imemreq_addr;
  logic [31:0] imemresp_data;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic [31:0] in0, in1, in2;
  logic [31:0] out0, out1, out2;
  logic        trace_val;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;

  proc_scycle dut (
    .clk            (clk),
    .rst            (rst),
    .imemreq_val    (imemreq_val),
    .imemreq_addr   (imemreq_addr),
    .imemresp_data  (imemresp_data),
    .dmemreq_val    (dmemreq_val),
    .dmemreq_type   (dmemreq_type),
    .dmemreq_addr   (dmemreq_addr),
    .dmemreq_wdata  (dmemreq_wdata),
    .dmemresp_rdata (dmemresp_rdata),
    .in0            (in0),
    .in1            (in1),
    .in2            (in2),
    .out0           (out0),
    .out1           (out1),
    .out2           (out2),
    .trace_val      (trace_val),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];

  assign imemresp_data  = (imemreq_addr[31:10] == 22'd0 && imemreq_addr[1:0] == 2'd0)
                          ? imem[imemreq_addr[9:2]] : 32'd0;
  assign dmemresp_rdata = (dmemreq_addr[31:10] == 22'd0 && dmemreq_addr[1:0] == 2'd0)
                          ? dmem[dmemreq_addr[9:2]] : 32'd0;

  always @(posedge clk) begin
    if (dmemreq_val && dmemreq_type && dmemreq_addr[31:10] == 22'd0 && dmemreq_addr[1:0] == 2'd0)
      dmem[dmemreq_addr[9:2]] <= dmemreq_wdata;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] f_r(input logic [6:0] f7, input int rd, input int rs1, input int rs2);
    logic [4:0] d, a, b;
    d = rd[4:0]; a = rs1[4:0]; b = rs2[4:0];
    return {f7, b, a, 3'b000, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] f_add(input int rd, input int rs1, input int rs2);
    return f_r(7'b0000000, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] f_mul(input int rd, input int rs1, input int rs2);
    return f_r(7'b0000001, rd, rs1, rs2);
  endfunction
  function automatic logic [31:0] f_i(input logic [6:0] op, input logic [2:0] f3, input int rd, input int rs1, input int imm);
    logic [11:0] im; logic [4:0] d, a;
    im = imm[11:0]; d = rd[4:0]; a = rs1[4:0];
    return {im, a, f3, d, op};
  endfunction
  function automatic logic [31:0] f_addi(input int rd, input int rs1, input int imm);
    return f_i(7'b0010011, 3'b000, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] f_lw(input int rd, input int rs1, input int imm);
    return f_i(7'b0000011, 3'b010, rd, rs1, imm);
  endfunction
  function automatic logic [31:0] f_sw(input int rs2, input int rs1, input int imm);
    logic [11:0] im; logic [4:0] a, b;
    im = imm[11:0]; a = rs1[4:0]; b = rs2[4:0];
    return {im[11:5], b, a, 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] f_bne(input int rs1, input int rs2, input int imm);
    logic [12:0] im; logic [4:0] a, b;
    im = imm[12:0]; a = rs1[4:0]; b = rs2[4:0];
    return {im[12], im[10:5], b, a, 3'b001, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] f_jal(input int rd, input int imm);
    logic [20:0] im; logic [4:0] d;
    im = imm[20:0]; d = rd[4:0];
    return {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
  endfunction
  function automatic logic [31:0] f_jr(input int rs1);
    logic [4:0] a;
    a = rs1[4:0];
    return {12'd0, a, 3'b000, 5'd0, 7'b1100111};
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] data;
    logic        dval;
    logic        dtype;
    logic [31:0] daddr;
    logic [31:0] dwdata;
  } vec_t;

  vec_t vecs [0:63];
  int   nvec = 0;

  task automatic add_vec(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] data,
                         input logic dval, input logic dtype, input logic [31:0] daddr,
                         input logic [31:0] dwdata);
    vecs[nvec] = '{pc, inst, data, dval, dtype, daddr, dwdata};
    nvec++;
  endtask

  initial begin
    bit found;
    rst = 1'b0;
    in0 = 32'd5;
    in1 = 32'h1234;
    in2 = 32'h777;
    for (int i = 0; i < 256; i++) imem[i] = 32'd0;

    // Expected commit sequence, in execution order
    add_vec(32'h00, f_addi(1, 0, 2),     32'd2,        0, 0, 0, 0);
    add_vec(32'h04, f_addi(2, 0, 3),     32'd3,        0, 0, 0, 0);
    add_vec(32'h08, f_mul(3, 1, 2),      32'd6,        0, 0, 0, 0);
    add_vec(32'h0C, f_add(4, 1, 2),      32'd5,        0, 0, 0, 0);
    add_vec(32'h10, f_jal(1, 32'h70),    32'h14,       0, 0, 0, 0);
    add_vec(32'h80, f_addi(5, 0, -1),    32'hFFFFFFFF, 0, 0, 0, 0);
    add_vec(32'h84, f_mul(3, 0, 5),      32'd0,        0, 0, 0, 0);
    add_vec(32'h88, f_jr(1),             32'd0,        0, 0, 0, 0);
    add_vec(32'h14, f_bne(4, 2, 8),      32'd0,        0, 0, 0, 0);
    add_vec(32'h1C, f_bne(2, 2, 8),      32'd0,        0, 0, 0, 0);
    add_vec(32'h20, f_addi(8, 0, 256),   32'h100,      0, 0, 0, 0);
    add_vec(32'h24, f_mul(8, 8, 8),      32'h10000,    0, 0, 0, 0);
    add_vec(32'h28, f_mul(3, 8, 8),      32'd0,        0, 0, 0, 0);
    add_vec(32'h2C, f_addi(9, 0, -3),    32'hFFFFFFFD, 0, 0, 0, 0);
    add_vec(32'h30, f_addi(10, 0, -5),   32'hFFFFFFFB, 0, 0, 0, 0);
    add_vec(32'h34, f_mul(3, 9, 10),     32'd15,       0, 0, 0, 0);
    add_vec(32'h38, f_addi(12, 0, 2),    32'd2,        0, 0, 0, 0);
    add_vec(32'h3C, f_mul(3, 5, 12),     32'hFFFFFFFE, 0, 0, 0, 0);
    add_vec(32'h40, f_mul(0, 9, 10),     32'd0,        0, 0, 0, 0);
    add_vec(32'h44, f_addi(13, 0, 7),    32'd7,        0, 0, 0, 0);
    add_vec(32'h48, f_addi(14, 0, 42),   32'h2A,       0, 0, 0, 0);
    add_vec(32'h4C, f_sw(14, 0, 256),    32'd0,        1, 1, 32'h100, 32'h2A);
    add_vec(32'h50, f_lw(4, 0, 256),     32'h2A,       1, 0, 32'h100, 32'h0);
    add_vec(32'h54, f_addi(16, 0, 1024), 32'h400,      0, 0, 0, 0);
    add_vec(32'h58, f_addi(17, 0, 8),    32'd8,        0, 0, 0, 0);
    add_vec(32'h5C, f_mul(16, 16, 17),   32'h2000,     0, 0, 0, 0);
    add_vec(32'h60, f_lw(5, 16, 0),      32'd5,        0, 0, 0, 0);
    add_vec(32'h64, f_mul(6, 5, 5),      32'd25,       0, 0, 0, 0);
    add_vec(32'h68, f_sw(6, 16, 4),      32'd0,        0, 0, 0, 0);
    add_vec(32'h6C, f_sw(14, 16, 8),     32'd0,        0, 0, 0, 0);
    add_vec(32'h70, f_lw(18, 16, 8),     32'h777,      0, 0, 0, 0);
    add_vec(32'h74, {12'd100, 5'd0, 3'b000, 5'd5, 7'b0001011}, 32'd0, 0, 0, 0, 0);
    add_vec(32'h78, f_add(19, 5, 0),     32'd5,        0, 0, 0, 0);
    add_vec(32'h7C, f_jal(0, 0),         32'd0,        0, 0, 0, 0);
    add_vec(32'h7C, f_jal(0, 0),         32'd0,        0, 0, 0, 0);

    for (int i = 0; i < nvec; i++) imem[vecs[i].pc[9:2]] = vecs[i].inst;
    imem[32'h18 >> 2] = f_addi(7, 0, 99);  // must be skipped by the taken bne

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imemreq_val", {31'd0, imemreq_val}, 32'd0);
    chk("rst_pc", imemreq_addr, 32'd0);
    chk("rst_trace_val", {31'd0, trace_val}, 32'd0);
    chk("rst_dmemreq_val", {31'd0, dmemreq_val}, 32'd0);
    chk("rst_out0", out0, 32'd0);
    chk("rst_out1", out1, 32'd0);
    chk("rst_out2", out2, 32'd0);
    rst = 1'b1;

    // Table-driven program run, one commit per cycle
    for (int i = 0; i < nvec; i++) begin
      #1;
      chk($sformatf("v%0d_trace_val", i), {31'd0, trace_val}, 32'd1);
      chk($sformatf("v%0d_imemreq_val", i), {31'd0, imemreq_val}, 32'd1);
      chk($sformatf("v%0d_trace_addr", i), trace_addr, vecs[i].pc);
      chk($sformatf("v%0d_trace_data", i), trace_data, vecs[i].data);
      chk($sformatf("v%0d_dmemreq_val", i), {31'd0, dmemreq_val}, {31'd0, vecs[i].dval});
      if (vecs[i].dval) begin
        chk($sformatf("v%0d_dmemreq_type", i), {31'd0, dmemreq_type}, {31'd0, vecs[i].dtype});
        chk($sformatf("v%0d_dmemreq_addr", i), dmemreq_addr, vecs[i].daddr);
        if (vecs[i].dtype)
          chk($sformatf("v%0d_dmemreq_wdata", i), dmemreq_wdata, vecs[i].dwdata);
      end
      @(negedge clk);
    end
    #1;
    chk("end_out0", out0, 32'd0);
    chk("end_out1", out1, 32'd25);
    chk("end_out2", out2, 32'h2A);
    chk("end_dmem_0x100", dmem[32'h100 >> 2], 32'h2A);

    // Reset asserted mid-run clears outputs and trace immediately
    rst = 1'b0;
    #1;
    chk("mid_trace_val", {31'd0, trace_val}, 32'd0);
    chk("mid_imemreq_val", {31'd0, imemreq_val}, 32'd0);
    chk("mid_dmemreq_val", {31'd0, dmemreq_val}, 32'd0);
    chk("mid_pc", imemreq_addr, 32'd0);
    chk("mid_out1", out1, 32'd0);
    chk("mid_out2", out2, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("restart_trace_val", {31'd0, trace_val}, 32'd1);
    chk("restart_trace_addr", trace_addr, 32'd0);
    chk("restart_trace_data", trace_data, 32'd2);
    @(negedge clk);
    #1;
    chk("restart2_trace_addr", trace_addr, 32'd4);

    // Reset during the sw to out1 must abort that store
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (trace_addr == 32'h68) found = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    chk("reach_sw_out1", {31'd0, found}, 32'd1);
    if (found) begin
      chk("pre_abort_out1", out1, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_out1", out1, 32'd0);
      chk("abort_pc", imemreq_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_restart_addr", trace_addr, 32'd0);
      chk("abort_restart_data", trace_data, 32'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
